// File: rtl/retire_unit_n_pkg.sv
// rtl/retire_unit_n_pkg.sv - shared types for the N-wide retire stage
package retire_unit_n_pkg;

   localparam int PR_W = 6;
   localparam int XLEN = 32;

   // One ROB head entry as seen by retire
   typedef struct packed {
      logic            completed;
      logic [4:0]      arch_reg;
      logic [PR_W-1:0] t_new;
      logic [PR_W-1:0] t_old;
      logic            is_store;
      logic            halt;
      logic            mispredict;
      logic [XLEN-1:0] target_pc;
   } rob_entry_packet_t;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_SQUASH = 2'd1,
      ST_HALT   = 2'd2
   } retire_state_t;

endpackage

// File: rtl/retire_unit_n_prefix_sel.sv
// rtl/retire_unit_n_prefix_sel.sv - picks the in-order retiring prefix of the ROB head
module retire_prefix_sel
   import retire_unit_n_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] valid,
   input  logic [WIDTH-1:0] completed,
   input  logic [WIDTH-1:0] is_store,
   input  logic [WIDTH-1:0] halt,
   input  logic [WIDTH-1:0] mispredict,
   input  logic             sq_commit_ready,
   input  retire_state_t    state,
   output logic [WIDTH-1:0] retire_en,
   output logic             term_valid,
   output logic [IDX_W-1:0] term_idx
);

   logic stop;
   logic store_seen;

   // Scan oldest (WIDTH-1) to youngest; first blocked slot or a retiring halt/mispredict ends the prefix
   always_comb begin
      retire_en  = '0;
      term_valid = 1'b0;
      term_idx   = '0;
      stop       = (state != ST_RUN);
      store_seen = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!stop) begin
            if (!(valid[i] && completed[i])) begin
               stop = 1'b1;
            end else if (is_store[i] && (store_seen || !sq_commit_ready)) begin
               stop = 1'b1;
            end else begin
               retire_en[i] = 1'b1;
               if (is_store[i]) store_seen = 1'b1;
               if (halt[i] || mispredict[i]) begin
                  stop       = 1'b1;
                  term_valid = 1'b1;
                  term_idx   = IDX_W'(i);
               end
            end
         end
      end
   end

endmodule

// File: rtl/retire_unit_n.sv
// rtl/retire_unit_n.sv - N-wide in-order retire with squash, halt and retire counter
module retire_unit_n
   import retire_unit_n_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int CNT_W = 64
) (
   input  logic                                clock,
   input  logic                                reset,
   input  rob_entry_packet_t [WIDTH-1:0]       rob_head_entry,
   input  logic [WIDTH-1:0]                    rob_head_valid,
   input  logic                                sq_commit_ready,
   output logic [WIDTH-1:0]                    retire_en,
   output logic [$clog2(WIDTH+1)-1:0]          rob_retire_num,
   output logic [WIDTH-1:0]                    map_en,
   output logic [WIDTH-1:0][4:0]               map_ar,
   output logic [WIDTH-1:0][PR_W-1:0]          map_ar_pr,
   output logic [WIDTH-1:0]                    free_en,
   output logic [WIDTH-1:0][PR_W-1:0]          Tolds_out,
   output logic                                st_commit,
   output logic                                squash,
   output logic [XLEN-1:0]                     squash_pc,
   output logic                                halted,
   output logic [CNT_W-1:0]                    retired_insts
);

   localparam int NUM_W = $clog2(WIDTH + 1);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   retire_state_t    state_q, state_d;
   logic             squash_q, squash_d;
   logic [XLEN-1:0]  squash_pc_q, squash_pc_d;
   logic [CNT_W-1:0] retired_insts_q, retired_insts_d;

   logic [WIDTH-1:0] completed_v, is_store_v, halt_v, mispredict_v;
   logic [WIDTH-1:0] sel_en;
   logic             term_valid;
   logic [IDX_W-1:0] term_idx;

   // Unpack per-slot flags for the prefix selector
   always_comb begin
      completed_v  = '0;
      is_store_v   = '0;
      halt_v       = '0;
      mispredict_v = '0;
      for (int i = 0; i < WIDTH; i++) begin
         completed_v[i]  = rob_head_entry[i].completed;
         is_store_v[i]   = rob_head_entry[i].is_store;
         halt_v[i]       = rob_head_entry[i].halt;
         mispredict_v[i] = rob_head_entry[i].mispredict;
      end
   end

   retire_prefix_sel #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_prefix_sel (
      .valid           (rob_head_valid),
      .completed       (completed_v),
      .is_store        (is_store_v),
      .halt            (halt_v),
      .mispredict      (mispredict_v),
      .sq_commit_ready (sq_commit_ready),
      .state           (state_q),
      .retire_en       (sel_en),
      .term_valid      (term_valid),
      .term_idx        (term_idx)
   );

   // Retire enables and map/free writes; reset suppresses every enable in its own cycle
   always_comb begin
      retire_en      = reset ? '0 : sel_en;
      rob_retire_num = '0;
      st_commit      = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         rob_retire_num = rob_retire_num + NUM_W'(retire_en[i]);
         st_commit      = st_commit | (retire_en[i] & rob_head_entry[i].is_store);
         map_en[i]      = retire_en[i] & (rob_head_entry[i].arch_reg != 5'd0);
         free_en[i]     = map_en[i];
         map_ar[i]      = rob_head_entry[i].arch_reg;
         map_ar_pr[i]   = rob_head_entry[i].t_new;
         Tolds_out[i]   = rob_head_entry[i].t_old;
      end
   end

   // Next state: a retiring halt wins over a mispredict on the same slot
   always_comb begin
      state_d         = state_q;
      squash_d        = 1'b0;
      squash_pc_d     = squash_pc_q;
      retired_insts_d = retired_insts_q + CNT_W'(rob_retire_num);
      case (state_q)
         ST_RUN: begin
            if (term_valid) begin
               if (rob_head_entry[term_idx].halt) begin
                  state_d = ST_HALT;
               end else if (rob_head_entry[term_idx].mispredict) begin
                  state_d     = ST_SQUASH;
                  squash_d    = 1'b1;
                  squash_pc_d = rob_head_entry[term_idx].target_pc;
               end
            end
         end
         ST_SQUASH: state_d = ST_RUN;
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_RUN;
      endcase
   end

   // State, squash and counter registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= ST_RUN;
         squash_q        <= 1'b0;
         squash_pc_q     <= '0;
         retired_insts_q <= '0;
      end else begin
         state_q         <= state_d;
         squash_q        <= squash_d;
         squash_pc_q     <= squash_pc_d;
         retired_insts_q <= retired_insts_d;
      end
   end

   assign squash        = squash_q;
   assign squash_pc     = squash_pc_q;
   assign halted        = (state_q == ST_HALT);
   assign retired_insts = retired_insts_q;

endmodule

// File: doc/retire_unit_n.md
Name: retire_unit_n

Overview:
- Parametrised, stateful successor to the 3-wide retire stage.
- Retires an in-order prefix of up to WIDTH completed ROB head entries per cycle, writing the architectural map table and the free list.
- Gates store commit through a store-queue handshake and raises a registered precise-squash on mispredicted branches.
- Latches a terminal HALT state when a halt instruction retires, and keeps a retired-instruction counter.

Parameters:
- WIDTH, 3, retire slots per cycle; slot WIDTH-1 is the oldest (ROB head).
- CNT_W, 64, width of retired-instruction counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- rob_head_entry  in  [WIDTH-1:0] ROB_ENTRY_PACKET  head entries, oldest at WIDTH-1
- rob_head_valid  in  WIDTH  entry occupied
- sq_commit_ready  in  1  store queue accepts one store commit this cycle
- retire_en  out  WIDTH  slot retires this cycle (ROB pops these)
- rob_retire_num  out  $clog2(WIDTH+1)  popcount of retire_en
- map_en  out  WIDTH  write arch map: retire_en & (arch_reg!=0)
- map_ar  out  [WIDTH-1:0][4:0]  arch_reg per slot
- map_ar_pr  out  [WIDTH-1:0][`PR-1:0]  Tnew per slot
- free_en  out  WIDTH  free Told: same as map_en
- Tolds_out  out  [WIDTH-1:0][`PR-1:0]  Told per slot
- st_commit  out  1  a store retires this cycle
- squash  out  1  registered flush pulse
- squash_pc  out  [`XLEN-1:0]  registered redirect target
- halted  out  1  HALT state
- retired_insts  out  CNT_W  running retire count

Behaviour:
- Reset: state=RUN; squash=0, squash_pc=0, halted=0, retired_insts=0.
- Reset gates all combinational enables (retire_en, map_en, free_en, st_commit) to 0 in the reset cycle.
- States:
  - RUN: normal operation.
  - SQUASH: exactly one cycle; retire_en=0; then returns to RUN.
  - HALT: terminal; retire_en=0 until reset.
- Retire rule (RUN only), slots scanned from WIDTH-1 downward; slot i retires iff all older slots retire and all of:
  - valid & completed;
  - if is_store: it is the first store in this cycle's prefix and sq_commit_ready=1;
  - no older slot in the prefix has mispredict=1 or halt=1.
- Scan termination:
  - The first failing slot stops the scan.
  - A retiring mispredict or halt slot is the last slot retired that cycle.
  - At most one store per cycle; a second store stops the scan.
- Map/free outputs are combinational from rob_head_entry. Enables fall to 0 for slots with arch_reg==0.
- st_commit = OR over retire_en & is_store.
- Mispredict: if a retiring slot has mispredict=1:
  - next cycle squash=1, squash_pc=that slot's target_pc, state=SQUASH;
  - squash deasserts the following cycle;
  - squash_pc holds its last value.
- Halt: if a retiring slot has halt=1, next cycle halted=1 and state=HALT.
  - The halt slot itself counts as retired.
  - Halt takes priority over a mispredict on the same slot: no squash.
- Counter: retired_insts += rob_retire_num each cycle, wraps modulo 2^CNT_W.
- Boundaries:
  - Non-completed head: retire_en all 0, no state change.
  - Invalid slots behave as non-completed.
  - sq_commit_ready=0 blocks the store slot and all younger slots; older slots still retire.
  - Reset during SQUASH or HALT returns to RUN with squash=0 in the following cycle.

Decomposition:
- sys_defs ROB_ENTRY_PACKET gains fields: is_store, halt, mispredict, target_pc.
- A retire_state_t enum (RUN, SQUASH, HALT) goes in the shared package.
- One sub-module, retire_prefix_sel (combinational):
  - inputs: entries, valid, sq_commit_ready, state;
  - outputs: retire_en and the index of a terminating mispredict/halt slot.
- The top module holds the FSM, squash registers and counter.

Test Plan:
1. WIDTH=3; slots 2,1 completed, slot 0 not completed -> retire_en=3'b110, rob_retire_num=2, retired_insts +2 next cycle.
2. Slot 2 store, slot 1 store, slot 0 ALU, all completed, sq_commit_ready=1 -> retire_en=3'b100, st_commit=1; same stimulus with sq_commit_ready=0 -> retire_en=3'b000.
3. Slot 1 mispredict with target_pc=32'h100, all completed -> retire_en=3'b110; next cycle squash=1, squash_pc=32'h100, retire_en=0; cycle after that squash=0.
4. Slot 2 halt, slots 1,0 completed -> retire_en=3'b100; halted=1 thereafter, retire_en=0 for 10 further cycles; reset clears halted.
5. Slot 2 with arch_reg=0 completed -> retire_en[2]=1, map_en[2]=0, free_en[2]=0.
6. WIDTH=4 build, all four completed ALU ops for 3 cycles -> retire_en=4'b1111 each cycle, retired_insts=12.
